// File: rtl/audio_play_sched_if.sv
// ---------------------------------------------------------------------------
// audio_play_sched_if
// Groups the sample-fetch handshake (scheduler <-> memory) and the sample
// output strobe (scheduler -> serial shifter) of audio_play_sched.
//   dma_req     scheduler -> memory   sample fetch request
//   dma_ack     memory -> scheduler   one-cycle; dma_data valid this cycle
//   dma_data    memory -> scheduler   {left[15:0], right[15:0]}
//   dma_last    memory -> scheduler   with dma_ack: final sample of stream
//   out_valid   scheduler -> shifter  one-cycle strobe
//   out_sample  scheduler -> shifter  sample, zero on underrun
// master: the scheduler side. slave: memory/shifter side.
// ---------------------------------------------------------------------------
interface audio_play_sched_if;
   logic        dma_req;
   logic        dma_ack;
   logic [31:0] dma_data;
   logic        dma_last;
   logic        out_valid;
   logic [31:0] out_sample;

   modport master (
      output dma_req,
      input  dma_ack,
      input  dma_data,
      input  dma_last,
      output out_valid,
      output out_sample
   );

   modport slave (
      input  dma_req,
      output dma_ack,
      output dma_data,
      output dma_last,
      input  out_valid,
      input  out_sample
   );
endinterface

// File: rtl/audio_play_sched.sv
// ---------------------------------------------------------------------------
// audio_play_sched
// Sequences audio playback after the op decoder flags a start command:
// fetches stereo samples over a req/ack handshake into a small FIFO and
// emits one sample per rate tick (44 kHz, or 22 kHz when op[12]=1 at start).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   op[15:0]       op word; only op[12] used, sampled with audio_starts
//   audio_starts   start strobe (accepted only in IDLE)
//   all_1_packet   abort strobe, highest priority
//   sample_tick    one-cycle 44.1 kHz strobe
//   bus            audio_play_sched_if.master: dma_* fetch, out_valid/out_sample
//   playing        high in PREFILL, PLAY and DRAIN
//   underrun       sticky, cleared by the next accepted audio_starts
//   underrun_cnt   [7:0] saturating count of empty-FIFO emit ticks
//                  (present only when AUDIO_UNDERRUN_CNT_EN is defined)
// Optional feature macro: AUDIO_UNDERRUN_CNT_EN
// ---------------------------------------------------------------------------
module audio_play_sched #(
   parameter int FIFO_DEPTH = 4,
   parameter int PREFETCH   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          op,
   input  logic                 audio_starts,
   input  logic                 all_1_packet,
   input  logic                 sample_tick,
   audio_play_sched_if.master   bus,
   output logic                 playing,
   output logic                 underrun
`ifdef AUDIO_UNDERRUN_CNT_EN
   ,
   output logic [7:0]           underrun_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, PREFILL, PLAY, DRAIN} state_t;

   state_t             state_reg, state_next;
   logic [31:0]        mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg, count_next;
   logic               out_valid_reg;
   logic [31:0]        out_sample_reg;
   logic               underrun_reg;
   logic               rate_22k_reg;
   logic               div_reg;
   logic               req, push, pop, emit, active, fifo_empty, fifo_full;

   // Only op[12] carries information for this block.
   logic op_unused;
   assign op_unused = ^{op[15:13], op[11:0]};

   always_comb begin
      state_next = state_reg;
      active     = (state_reg == PLAY) || (state_reg == DRAIN);
      fifo_empty = (count_reg == '0);
      fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
      req        = 1'b0;
      // In 22 kHz mode every other tick is swallowed: emit when divider was 0.
      emit       = active && sample_tick && (!rate_22k_reg || !div_reg);
      if ((state_reg == PREFILL) || (state_reg == PLAY))
         req = !fifo_full;
      // An ack without an outstanding request never pushes, so a full FIFO
      // is never overwritten.
      push       = req && bus.dma_ack;
      pop        = emit && !fifo_empty;
      count_next = count_reg + CNT_W'(push) - CNT_W'(pop);

      case (state_reg)
         IDLE: begin
            if (audio_starts)
               state_next = PREFILL;
         end
         PREFILL: begin
            if (push && bus.dma_last)
               state_next = DRAIN;
            else if (count_next >= CNT_W'(PREFETCH))
               state_next = PLAY;
         end
         PLAY: begin
            if (push && bus.dma_last)
               state_next = DRAIN;
         end
         DRAIN: begin
            // Leave in the same cycle as the final pop so an empty DRAIN
            // never sees an emit tick.
            if (count_next == '0)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      // Abort wins over every other same-cycle event.
      if (all_1_packet) begin
         state_next = IDLE;
         push       = 1'b0;
         pop        = 1'b0;
         emit       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= bus.dma_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         out_valid_reg  <= 1'b0;
         out_sample_reg <= '0;
         underrun_reg   <= 1'b0;
         rate_22k_reg   <= 1'b0;
         div_reg        <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= emit;
         if (all_1_packet) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
         end else begin
            if (push)
               wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
               rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
         end
         if (pop)
            out_sample_reg <= mem[rd_ptr_reg];
         else if (emit)
            out_sample_reg <= '0;
         if (emit && fifo_empty && (state_reg == PLAY))
            underrun_reg <= 1'b1;
         if ((state_reg == IDLE) && audio_starts && !all_1_packet) begin
            rate_22k_reg <= op[12];
            underrun_reg <= 1'b0;
            div_reg      <= 1'b0;
         end else if (active && sample_tick && !all_1_packet) begin
            // The divider only advances once playback is emitting, so the
            // first tick after PREFILL always produces a sample.
            div_reg <= ~div_reg;
         end
      end
   end

`ifdef AUDIO_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         underrun_cnt_reg <= '0;
      end else if ((state_reg == IDLE) && audio_starts && !all_1_packet) begin
         underrun_cnt_reg <= '0;
      end else if (emit && fifo_empty && (state_reg == PLAY) &&
                   (underrun_cnt_reg != 8'hff)) begin
         underrun_cnt_reg <= underrun_cnt_reg + 8'd1;
      end
   end

   assign underrun_cnt = underrun_cnt_reg;
`endif

   assign bus.dma_req    = req;
   assign bus.out_valid  = out_valid_reg;
   assign bus.out_sample = out_sample_reg;
   assign playing        = (state_reg != IDLE);
   assign underrun       = underrun_reg;

endmodule
